processor: RTL and testbench



---
 rtl/mips_pkg.sv | 48 ++++
 rtl/regfile.sv | 28 ++
 rtl/processor.sv | 163 ++++++++++++++++
 tb/tb_processor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, ALU ops and control bundle for the MIPS-subset core
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

  typedef struct packed {
    logic reg_dst;
    logic reg_write;
    logic alu_src;
    logic zero_ext;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic branch_ne;
    logic jump;
    logic jump_reg;
  } ctrl_t;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, two async read ports, one sync write port
module regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  // r0 is never written, so it holds its reset value; reads are gated anyway
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/processor.sv
// rtl/processor.sv - single-cycle MIPS-subset core: decode, ALU and next-PC inline
module processor
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Inst,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Addr,
  output logic [31:0] Din,
  input  logic [31:0] Dout
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = Inst[31:26];
  assign rs     = Inst[25:21];
  assign rt     = Inst[20:16];
  assign rd     = Inst[15:11];
  assign shamt  = Inst[10:6];
  assign funct  = Inst[5:0];
  assign imm    = Inst[15:0];
  assign target = Inst[25:0];

  ctrl_t   ctrl;
  alu_op_e alu_op;

  always_comb begin
    ctrl   = '0;
    alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_JR: begin
            ctrl.reg_write = 1'b0;
            ctrl.jump_reg  = 1'b1;
          end
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        alu_op         = ALU_AND;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        alu_op         = ALU_OR;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_op         = ALU_SLT;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: ctrl.branch = 1'b1;
      OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ctrl = '0;
    endcase
  end

  logic [31:0] rd1, rd2, wb_data, imm_ext, alu_b, alu_y;
  logic [4:0]  wb_addr;

  assign wb_addr = ctrl.reg_dst ? rd : rt;
  assign wb_data = ctrl.mem_to_reg ? Dout : alu_y;

  regfile u_regfile (
    .clock (clock),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (wb_addr),
    .we    (ctrl.reg_write),
    .wd    (wb_data),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  assign imm_ext = ctrl.zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = ctrl.alu_src ? imm_ext : rd2;

  // Shifts take their operand from rt; the shift amount is always the shamt field
  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD: alu_y = rd1 + alu_b;
      ALU_SUB: alu_y = rd1 - alu_b;
      ALU_AND: alu_y = rd1 & alu_b;
      ALU_OR:  alu_y = rd1 | alu_b;
      ALU_SLT: alu_y = {31'b0, $signed(rd1) < $signed(alu_b)};
      ALU_SLL: alu_y = alu_b << shamt;
      ALU_SRL: alu_y = alu_b >> shamt;
      default: alu_y = '0;
    endcase
  end

  assign MemRead  = ctrl.mem_read & ~reset;
  assign MemWrite = ctrl.mem_write & ~reset;
  assign Addr     = alu_y;
  assign Din      = rd2;

  logic [31:0] pc_plus4, branch_target, pc_next;
  logic        equal;

  assign pc_plus4      = PC + 32'd4;
  assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign equal         = (rd1 == rd2);

  // jr registers hold a word index, hence the shift back to a byte address
  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jump_reg) begin
      pc_next = {rd1[29:0], 2'b00};
    end else if (ctrl.jump) begin
      pc_next = {pc_plus4[31:28], target, 2'b00};
    end else if (ctrl.branch && (ctrl.branch_ne ? !equal : equal)) begin
      pc_next = branch_target;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) PC <= RESET_PC;
    else       PC <= pc_next;
  end

endmodule

// File: tb/tb_processor.sv
// tb/tb_processor.sv - scoreboard bench with an instruction-level reference model
module tb_processor;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] PC, Inst, Addr, Din, Dout;
  logic        MemRead, MemWrite;

  processor #(.RESET_PC(32'h0000_0000)) dut (
    .clock    (clock),
    .reset    (reset),
    .PC       (PC),
    .Inst     (Inst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .Din      (Din),
    .Dout     (Dout)
  );

  always #5 clock = ~clock;

  logic [31:0] dmem [64];
  assign Dout = dmem[Addr[7:2]];

  typedef struct {
    logic [31:0] pc;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [64];
  logic [31:0] imem [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  // Executes one instruction on the architectural model and queues what the core must show
  task automatic model_step(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] a, b, se, ze, nxt, res;
    logic [4:0]  dst;
    bit          wr_reg;
    a      = m_regs[ins[25:21]];
    b      = m_regs[ins[20:16]];
    se     = {{16{ins[15]}}, ins[15:0]};
    ze     = {16'h0, ins[15:0]};
    nxt    = m_pc + 32'd4;
    res    = 32'h0;
    dst    = ins[20:16];
    wr_reg = 1'b0;
    e.pc = m_pc; e.rd = 1'b0; e.wr = 1'b0; e.addr = 32'h0; e.din = 32'h0;
    case (ins[31:26])
      6'h00: begin
        dst    = ins[15:11];
        wr_reg = 1'b1;
        case (ins[5:0])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: res = b << ins[10:6];
          6'h02: res = b >> ins[10:6];
          6'h08: begin wr_reg = 1'b0; nxt = a << 2; end
          default: wr_reg = 1'b0;
        endcase
      end
      6'h08: begin wr_reg = 1'b1; res = a + se; end
      6'h0C: begin wr_reg = 1'b1; res = a & ze; end
      6'h0D: begin wr_reg = 1'b1; res = a | ze; end
      6'h0A: begin wr_reg = 1'b1; res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h23: begin
        e.rd = 1'b1; e.addr = a + se;
        wr_reg = 1'b1; res = m_mem[e.addr[7:2]];
      end
      6'h2B: begin e.wr = 1'b1; e.addr = a + se; e.din = b; end
      6'h04: if (a == b) nxt = m_pc + 32'd4 + (se << 2);
      6'h05: if (a != b) nxt = m_pc + 32'd4 + (se << 2);
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    if (wr_reg && dst != 5'd0) m_regs[dst] = res;
    if (e.wr) m_mem[e.addr[7:2]] = b;
    m_pc = nxt;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", PC, e.pc);
        chk("mem_read", {31'b0, MemRead}, {31'b0, e.rd});
        chk("mem_write", {31'b0, MemWrite}, {31'b0, e.wr});
        if (e.rd || e.wr) chk("addr", Addr, e.addr);
        if (e.wr) chk("din", Din, e.din);
      end
    end
  end

  task automatic present(input logic [31:0] ins);
    Inst = ins;
    model_step(ins);
  endtask

  task automatic advance();
    logic        w;
    logic [31:0] wa, wd;
    @(negedge clock);
    w = MemWrite; wa = Addr; wd = Din;
    @(posedge clock);
    if (w) dmem[wa[7:2]] = wd;
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    present(ins);
    advance();
  endtask

  task automatic issue_chk(input logic [31:0] ins, input string name, input bit use_addr,
                           input logic [31:0] val);
    present(ins);
    #2;
    chk(name, use_addr ? Addr : Din, val);
    advance();
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm, boff;
    logic [5:0]  fn;
    rs   = 5'($urandom_range(0, 7));
    rt   = 5'($urandom_range(0, 7));
    rd   = 5'($urandom_range(0, 7));
    sh   = 5'($urandom_range(0, 31));
    imm  = 16'($urandom);
    boff = 16'($urandom_range(0, 15)) - 16'd8;
    case ($urandom_range(0, 7))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h2A;
      5: fn = 6'h00;
      6: fn = 6'h02;
      default: fn = 6'h21;
    endcase
    case ($urandom_range(0, 15))
      0, 1, 2, 3: return enc_r(rs, rt, rd, sh, fn);
      4, 15:      return enc_i(6'h08, rs, rt, imm);
      5:          return enc_i(6'h0C, rs, rt, imm);
      6:          return enc_i(6'h0D, rs, rt, imm);
      7:          return enc_i(6'h0A, rs, rt, imm);
      8:          return enc_i(6'h23, rs, rt, imm);
      9:          return enc_i(6'h2B, rs, rt, imm);
      10:         return enc_i(6'h04, rs, rt, boff);
      11:         return enc_i(6'h05, rs, rt, boff);
      12:         return {6'h02, 26'($urandom)};
      13:         return enc_r(rs, 5'd0, 5'd0, 5'd0, 6'h08);
      default:    return enc_i(6'h0F, rs, rt, imm);
    endcase
  endfunction

  task automatic dump_regs();
    for (int r = 0; r < 32; r++) issue(enc_i(6'h2B, 5'd0, 5'(r), 16'(r * 4)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) begin
      dmem[i]  = $urandom;
      m_mem[i] = dmem[i];
      imem[i]  = 32'h0;
    end
    dmem[1] = 32'd8; m_mem[1] = 32'd8;
    model_reset();

    reset = 1'b1;
    Inst  = enc_i(6'h2B, 5'd0, 5'd0, 16'h0004);
    #2;
    chk("reset_pc", PC, 32'h0);
    chk("reset_memwrite", {31'b0, MemWrite}, 32'h0);
    Inst = 32'h8d210004;
    #1;
    chk("reset_memread", {31'b0, MemRead}, 32'h0);
    Inst = 32'h0;
    @(posedge clock); #1;
    chk("reset_hold_pc", PC, 32'h0);
    reset = 1'b0;

    issue(32'h0);
    chk("pc_after_reset", PC, 32'd4);

    issue(32'h20030007);
    issue(32'h00032880);
    issue_chk(enc_i(6'h2B, 5'd0, 5'd5, 16'h0), "sll_r5", 1'b0, 32'd28);
    issue(32'h20060004);
    issue(32'h00a62822);
    issue_chk(enc_i(6'h2B, 5'd0, 5'd5, 16'h0), "sub_r5", 1'b0, 32'd24);
    issue_chk(32'h8d210004, "lw_addr", 1'b1, 32'd4);
    issue_chk(32'had210008, "sw_din", 1'b0, 32'd8);
    issue(enc_i(6'h08, 5'd0, 5'd0, 16'h1234));
    issue_chk(enc_i(6'h2B, 5'd0, 5'd0, 16'h0), "r0_zero", 1'b0, 32'd0);

    for (int n = 0; n < 400; n++) issue(rand_inst());
    dump_regs();

    Inst  = enc_i(6'h2B, 5'd0, 5'd1, 16'h0004);
    reset = 1'b1;
    #1;
    chk("async_reset_pc", PC, 32'h0);
    chk("async_reset_memwrite", {31'b0, MemWrite}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    dump_regs();

    Inst  = 32'h0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    imem[1]  = 32'h20030007; imem[2]  = 32'h00602024; imem[3]  = 32'h00032880;
    imem[4]  = 32'h20060004; imem[5]  = 32'h200c0007; imem[6]  = 32'h200a0001;
    imem[7]  = 32'h20090000; imem[8]  = 32'h8d210004; imem[9]  = 32'h8d220008;
    imem[10] = 32'h0022582a; imem[11] = 32'had210008; imem[12] = 32'had220004;
    imem[13] = 32'h154b0002; imem[14] = 32'had210004; imem[15] = 32'had220008;
    imem[16] = 32'h21290004; imem[17] = 32'h1525fff6; imem[18] = 32'h20840001;
    imem[19] = 32'h00a62822; imem[20] = 32'h10640001; imem[21] = 32'h01800008;
    dmem[1] = 32'd8;  dmem[2] = 32'd9; dmem[3] = 32'd7; dmem[4] = 32'd10;
    dmem[5] = 32'd6;  dmem[6] = 32'd4; dmem[7] = 32'd14; dmem[8] = 32'd5;
    for (int i = 1; i <= 8; i++) m_mem[i] = dmem[i];

    cyc = 0;
    while (cyc < 550 && m_pc != 32'd88 && m_pc < 32'd256) begin
      issue(imem[m_pc[7:2]]);
      cyc++;
    end
    chk("sort_end_pc", PC, 32'd88);
    issue_chk(enc_i(6'h2B, 5'd0, 5'd4, 16'h0), "sort_r4", 1'b0, 32'd7);

    for (int i = 0; i < 64; i++) chk($sformatf("dmem_%0d", i), dmem[i], m_mem[i]);
    @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
